rsa_modexp_ctrl: RTL and testbench

- Square-and-multiply-always modular exponentiation controller: result = base^exponent mod modulus.
- Runs an internal sequential shift-add multiplier.
- Every reduction goes to the downstream non-restoring divider through its start/done handshake; the divider's remainder output is the only value this block consumes.
- Sits directly upstream of the divider in the RSA decryption path; ciphertext goes in as base and the private exponent as exponent.

---
 rtl/rsa_modexp_ctrl.sv | 172 +++++++++++++++++
 tb/tb_rsa_modexp_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/rsa_modexp_ctrl.sv
// Square-and-multiply-always modular exponentiation controller.
// Products come from an internal shift-add multiplier; every reduction goes through the external divider.
module rsa_modexp_ctrl #(
    parameter int WIDTH = 512,
    parameter int EXP_W = 512,
    parameter int DIV_W = 1025
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [EXP_W-1:0] exponent,
    input  logic [WIDTH-1:0] modulus,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             error,
    output logic             div_start,
    output logic [DIV_W-1:0] div_dividend,
    output logic [DIV_W-1:0] div_divisor,
    input  logic             div_done,
    input  logic [DIV_W-1:0] div_remainder
);

    generate
        if (DIV_W < 2*WIDTH+1) begin : g_bad_div_w
            $error("rsa_modexp_ctrl: DIV_W must be at least 2*WIDTH+1");
        end
    endgenerate

    localparam int PW  = 2*WIDTH;
    localparam int MCW = $clog2(WIDTH+1);
    localparam int ECW = $clog2(EXP_W+1);
    localparam logic [MCW-1:0] MUL_LAST = MCW'(WIDTH-1);
    localparam logic [ECW-1:0] EXP_LAST = ECW'(EXP_W-1);

    typedef enum logic [3:0] {
        IDLE, CHECK, RED_REQ, RED_WAIT, SQ_MUL, SQ_REQ, SQ_WAIT,
        ML_MUL, ML_REQ, ML_WAIT, UPDATE, FINISH
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] base_q, mod_q, r_q, b_q, t_q, result_q, mplier_q;
    logic [EXP_W-1:0] exp_q;
    logic [PW-1:0]    acc_q, mcand_q;
    logic [MCW-1:0]   mul_cnt;
    logic [ECW-1:0]   bit_cnt;
    logic             err_q;
    logic [DIV_W-1:0] dividend_q, divisor_q;

    logic [PW-1:0]    acc_next;
    logic [WIDTH-1:0] rem, r_upd;
    logic             mul_last, exp_last, rem_unused;

    assign acc_next   = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign rem        = div_remainder[WIDTH-1:0];
    assign rem_unused = ^div_remainder[DIV_W-1:WIDTH];
    // Exponent is shifted left each UPDATE, so the current bit is always the MSB.
    assign r_upd      = exp_q[EXP_W-1] ? t_q : r_q;
    assign mul_last   = (mul_cnt == MUL_LAST);
    assign exp_last   = (bit_cnt == EXP_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        div_start  = 1'b0;
        case (state)
            IDLE:     if (start) state_next = CHECK;
            CHECK:    begin busy = 1'b1; state_next = (mod_q == '0) ? FINISH : RED_REQ; end
            RED_REQ:  begin busy = 1'b1; div_start = 1'b1; state_next = RED_WAIT; end
            RED_WAIT: begin busy = 1'b1; if (div_done) state_next = SQ_MUL; end
            SQ_MUL:   begin busy = 1'b1; if (mul_last) state_next = SQ_REQ; end
            SQ_REQ:   begin busy = 1'b1; div_start = 1'b1; state_next = SQ_WAIT; end
            SQ_WAIT:  begin busy = 1'b1; if (div_done) state_next = ML_MUL; end
            ML_MUL:   begin busy = 1'b1; if (mul_last) state_next = ML_REQ; end
            ML_REQ:   begin busy = 1'b1; div_start = 1'b1; state_next = ML_WAIT; end
            ML_WAIT:  begin busy = 1'b1; if (div_done) state_next = UPDATE; end
            UPDATE:   begin busy = 1'b1; state_next = exp_last ? FINISH : SQ_MUL; end
            FINISH:   begin done = 1'b1; state_next = IDLE; end
            default:  state_next = IDLE;
        endcase
    end

    assign error        = done & err_q;
    assign result       = result_q;
    assign div_dividend = dividend_q;
    assign div_divisor  = divisor_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q     <= '0;
            mod_q      <= '0;
            exp_q      <= '0;
            r_q        <= '0;
            b_q        <= '0;
            t_q        <= '0;
            result_q   <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            mul_cnt    <= '0;
            bit_cnt    <= '0;
            err_q      <= 1'b0;
            dividend_q <= '0;
            divisor_q  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    base_q    <= base;
                    exp_q     <= exponent;
                    mod_q     <= modulus;
                    r_q       <= WIDTH'(1);
                    bit_cnt   <= '0;
                    err_q     <= 1'b0;
                    divisor_q <= DIV_W'(modulus);
                end
                CHECK: begin
                    if (mod_q == '0) begin
                        err_q    <= 1'b1;
                        result_q <= '0;
                    end else begin
                        dividend_q <= DIV_W'(base_q);
                    end
                end
                RED_WAIT: if (div_done) begin
                    b_q      <= rem;
                    acc_q    <= '0;
                    mcand_q  <= PW'(r_q);
                    mplier_q <= r_q;
                    mul_cnt  <= '0;
                end
                SQ_MUL, ML_MUL: begin
                    acc_q    <= acc_next;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    mul_cnt  <= mul_cnt + 1'b1;
                    if (mul_last) dividend_q <= DIV_W'(acc_next);
                end
                SQ_WAIT: if (div_done) begin
                    r_q      <= rem;
                    acc_q    <= '0;
                    mcand_q  <= PW'(rem);
                    mplier_q <= b_q;
                    mul_cnt  <= '0;
                end
                ML_WAIT: if (div_done) t_q <= rem;
                UPDATE: begin
                    r_q     <= r_upd;
                    exp_q   <= exp_q << 1;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (exp_last) begin
                        result_q <= r_upd;
                    end else begin
                        acc_q    <= '0;
                        mcand_q  <= PW'(r_upd);
                        mplier_q <= r_upd;
                        mul_cnt  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// Directed bench for rsa_modexp_ctrl with a fixed-latency behavioural divider.
module tb_rsa_modexp_ctrl;

    localparam int WIDTH = 16;
    localparam int EXP_W = 16;
    localparam int DIV_W = 33;
    localparam int L     = 5;
    localparam int LAT   = 1 + (1 + L) + EXP_W * (2 * (WIDTH + 1 + L) + 1) + 1;
    localparam int NREQ  = 2 * EXP_W + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] base = '0;
    logic [EXP_W-1:0] exponent = '0;
    logic [WIDTH-1:0] modulus = '0;
    logic             busy, done, error, div_start, div_done;
    logic [WIDTH-1:0] result;
    logic [DIV_W-1:0] div_dividend, div_divisor, div_remainder;

    rsa_modexp_ctrl #(.WIDTH(WIDTH), .EXP_W(EXP_W), .DIV_W(DIV_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base(base), .exponent(exponent),
        .modulus(modulus), .busy(busy), .done(done), .result(result), .error(error),
        .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_done(div_done), .div_remainder(div_remainder)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Divider model: remainder appears L cycles after the div_start cycle, no reset.
    logic             m_done = 1'b0;
    logic             inj = 1'b0;
    logic             m_pend = 1'b0;
    int               m_cnt = 0;
    logic [DIV_W-1:0] m_rem = '0;
    int               ds_cnt = 0;
    int               done_cnt = 0;

    assign div_done      = m_done | inj;
    assign div_remainder = m_rem;

    always @(negedge clk) begin
        m_done = 1'b0;
        if (div_start) begin
            m_pend = 1'b1;
            m_cnt  = L;
            m_rem  = (div_divisor == '0) ? '0 : div_dividend % div_divisor;
        end else if (m_pend) begin
            if (m_cnt == 1) begin
                m_done = 1'b1;
                m_pend = 1'b0;
            end
            m_cnt = m_cnt - 1;
        end
        if (div_start) ds_cnt++;
        if (done) done_cnt++;
    end

    task automatic run_op(input logic [15:0] b, input logic [15:0] e, input logic [15:0] m,
                          input bit poke, output logic [15:0] res, output logic err,
                          output int cyc, output int starts, output int dones);
        int ds0, dn0;
        @(negedge clk);
        base = b; exponent = e; modulus = m; start = 1'b1;
        ds0 = ds_cnt; dn0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        check_eq("busy_after_accept", busy, 1);
        while (!done) begin
            start = 1'b0;
            if (poke && cyc == 100) begin
                start = 1'b1; base = 16'd1234; exponent = 16'd7; modulus = 16'd11;
            end
            @(posedge clk); #1;
            cyc++;
            if (cyc > 4 * LAT) begin
                check_eq("timeout", cyc, LAT);
                break;
            end
        end
        start = 1'b0;
        res = result; err = error;
        @(negedge clk); @(negedge clk); @(negedge clk);
        check_eq("busy_after_done", busy, 0);
        check_eq("result_held", result, res);
        starts = ds_cnt - ds0;
        dones  = done_cnt - dn0;
    endtask

    logic [15:0] res;
    logic        err;
    int          cyc, starts, dones, cyc0, seen;

    initial begin
        #2;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_error", error, 0);
        check_eq("rst_result", result, 0);
        check_eq("rst_div_start", div_start, 0);
        check_eq("rst_div_dividend", div_dividend, 0);
        check_eq("rst_div_divisor", div_divisor, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_op(16'd2790, 16'd2753, 16'd3233, 1'b0, res, err, cyc, starts, dones);
        check_eq("rsa_result", res, 65);
        check_eq("rsa_error", err, 0);
        check_eq("rsa_latency", cyc, LAT);
        check_eq("rsa_done_once", dones, 1);
        check_eq("rsa_div_starts", starts, NREQ);

        run_op(16'd4, 16'd13, 16'd497, 1'b0, res, err, cyc, starts, dones);
        check_eq("pow_4_13", res, 445);

        run_op(16'd4, 16'd0, 16'd497, 1'b0, res, err, cyc, starts, dones);
        check_eq("exp0_result", res, 1);
        check_eq("exp0_latency", cyc, LAT);
        check_eq("exp0_div_starts", starts, NREQ);
        cyc0 = cyc;

        run_op(16'd4, 16'hFFFF, 16'd497, 1'b0, res, err, cyc, starts, dones);
        check_eq("expFFFF_latency", cyc, cyc0);
        check_eq("expFFFF_div_starts", starts, NREQ);

        run_op(16'd1000, 16'd3, 16'd7, 1'b0, res, err, cyc, starts, dones);
        check_eq("base_ge_mod", res, 6);

        run_op(16'd5, 16'd3, 16'd1, 1'b0, res, err, cyc, starts, dones);
        check_eq("mod1_result", res, 0);

        run_op(16'd5, 16'd3, 16'd0, 1'b0, res, err, cyc, starts, dones);
        check_eq("mod0_error", err, 1);
        check_eq("mod0_result", res, 0);
        check_eq("mod0_latency", cyc, 2);
        check_eq("mod0_div_starts", starts, 0);
        check_eq("mod0_done_once", dones, 1);

        run_op(16'd2790, 16'd2753, 16'd3233, 1'b1, res, err, cyc, starts, dones);
        check_eq("poke_result", res, 65);
        check_eq("poke_latency", cyc, LAT);
        check_eq("poke_done_once", dones, 1);

        // Reset while the first square is waiting on the divider.
        @(negedge clk);
        base = 16'd4; exponent = 16'd13; modulus = 16'd497; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 0;
        for (int k = 0; k < 200 && seen < 2; k++) begin
            @(posedge clk); #1;
            if (div_start) seen++;
        end
        check_eq("sq_req_reached", seen, 2);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_done", done, 0);
        check_eq("midrst_result", result, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        inj = 1'b1;
        @(negedge clk);
        inj = 1'b0;
        cyc0 = ds_cnt;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (busy || done || div_start) seen++;
        end
        check_eq("stale_done_ignored", seen, 0);
        check_eq("stale_no_div_start", ds_cnt - cyc0, 0);
        check_eq("stale_result", result, 0);

        run_op(16'd4, 16'd13, 16'd497, 1'b0, res, err, cyc, starts, dones);
        check_eq("after_rst_result", res, 445);
        check_eq("after_rst_latency", cyc, LAT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
